player_move_ctrl: RTL and testbench
===================================

// Module: player_move_ctrl
// PURPOSE
// - Per-frame player movement controller; direct upstream neighbour of the maze collision checker.
// - Proposes a candidate top-left position (probe) to the checker, waits for its registered verdict
//   (valid_player_position), then commits or discards the move.
// - X and Y are probed separately so the player slides along walls when moving diagonally.
// PARAMETERS
// - INIT_X        11'd15  committed X after reset (arena origin column 0)
// - INIT_Y        11'd48  committed Y after reset (arena origin row 0)
// - STEP          11'd1   pixels moved per axis per frame
// - CHECK_LATENCY 2       cycles from probe driven to verdict valid (checker is 1 FF + 1 settle)
// PORTS
// - clk                    in   1   system clock
// - resetN                 in   1   asynchronous active-low reset
// - startOfFrame           in   1   1-cycle pulse, once per video frame
// - key_up/key_down        in   1   level, debounced direction keys
// - key_left/key_right     in   1   level, debounced direction keys
// - valid_player_position  in   1   checker verdict for current probe (1 = free)
// - probe_topLeftX         out  11  candidate X driven to checker
// - probe_topLeftY         out  11  candidate Y driven to checker
// - probe_active           out  1   high while a probe is being evaluated (checker InsideRectangle)
// - topLeftX/topLeftY      out  11  committed player position (to drawing object)
// - moved                  out  1   1-cycle pulse when >=1 axis committed this frame
// BEHAVIOUR
// - Reset: state IDLE; topLeft = probe = INIT_X/INIT_Y; probe_active = 0; moved = 0.
// - FSM: IDLE -> PROBE_X -> PROBE_Y -> DONE -> IDLE.
// - IDLE: probe = committed position; on startOfFrame latch the 4 keys, go to PROBE_X.
// - Axis direction: right-only = +STEP, left-only = -STEP, both/none = no move (Y analogous: down +, up -).
// - PROBE_X with no X move: skip to PROBE_Y next cycle, probe_active stays 0.
// - PROBE_X with a move: probe X = topLeftX +/- STEP, probe Y = topLeftY.
//   - probe_active = 1 for exactly CHECK_LATENCY cycles (wait counter).
//   - On the last of those cycles sample valid_player_position: 1 -> topLeftX <= probe X next edge; 0 -> unchanged.
// - PROBE_Y: same, using the already-updated topLeftX; probe X = topLeftX.
// - DONE: moved = 1 if either axis committed; 1 cycle; then IDLE.
// - Worst-case frame latency: 2*CHECK_LATENCY + 3 cycles; well under one frame.
// - startOfFrame outside IDLE is ignored (no queueing).
// - Keys sampled only at startOfFrame; changes mid-sequence have no effect.
// - Arithmetic: unsigned 11-bit; without clamp, -STEP below 0 wraps mod 2^11 (checker must reject).
// - resetN asserted mid-sequence: immediate return to reset values; the partial move is lost.
// CONFIGURATION
// - PLAYER_BOUNDS_CLAMP_EN defined: a candidate outside [ARENA_MIN_X..ARENA_MAX_X] x [ARENA_MIN_Y..ARENA_MAX_Y]
//   is rejected without probing; that axis is skipped and probe_active stays 0.
// - Undefined: no bounds check; every move is probed and the checker verdict alone decides.
// STRUCTURE
// - Package bomber_pkg:
//   - typedef logic [10:0] coord_t;
//   - typedef enum {IDLE, PROBE_X, PROBE_Y, DONE} move_state_t;
//   - ARENA_MIN_X=15, ARENA_MAX_X=591, ARENA_MIN_Y=48, ARENA_MAX_Y=432, TILE_SIZE=32.
// - Single module; no sub-module (the wait counter is inline).
// TESTING
// - Reset, no keys, 3 frames -> topLeft stays (15,48), probe_active never 1, moved never 1.
// - key_right, valid=1 -> probe (16,48) held 2 cycles; topLeftX=16; moved pulses once.
// - key_right+key_down at (47,48), valid=0 during X probe, 1 during Y probe -> topLeft=(47,49): slide along wall.
// - key_left+key_right together -> no X probe; with key_up also pressed, only a Y probe to (x,47).
// - key_left at (15,48): with _EN defined -> no probe, position kept; without it -> probe X=14; valid=0 keeps 15.
// - resetN low during PROBE_Y -> all outputs at reset values asynchronously; the next startOfFrame resumes normally.

Source files
------------

// File: rtl/bomber_pkg.sv
// Shared types and arena geometry for the bomber player logic.
// Holds the coordinate type, the movement FSM state encoding and the
// per-axis step helpers used by the movement controller.
package bomber_pkg;

  typedef logic [10:0] coord_t;

  typedef enum logic [1:0] {
    IDLE,
    PROBE_X,
    PROBE_Y,
    DONE
  } move_state_t;

  // Playable arena in screen pixels (top-left corner of the player sprite).
  localparam coord_t ARENA_MIN_X = 11'd15;
  localparam coord_t ARENA_MAX_X = 11'd591;
  localparam coord_t ARENA_MIN_Y = 11'd48;
  localparam coord_t ARENA_MAX_Y = 11'd432;
  localparam coord_t TILE_SIZE   = 11'd32;

  // An axis moves only when exactly one of its two keys is held.
  function automatic logic axis_moves(input logic inc, input logic dec);
    return inc ^ dec;
  endfunction

  // Candidate coordinate for one axis; unsigned, so a decrement below 0 wraps.
  function automatic coord_t step_coord(input coord_t pos, input logic inc,
                                        input logic dec, input coord_t step);
    coord_t res;
    res = pos;
    if (inc && !dec) begin
      res = pos + step;
    end else if (dec && !inc) begin
      res = pos - step;
    end
    return res;
  endfunction

  // Inclusive range test used by the optional bounds clamp.
  function automatic logic in_range(input coord_t v, input coord_t lo,
                                    input coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/player_move_ctrl_if.sv
// Probe handshake between the player movement controller (master) and the
// maze collision checker (slave): candidate position out, verdict back.
interface player_move_ctrl_if;
  import bomber_pkg::*;

  coord_t probe_topLeftX;
  coord_t probe_topLeftY;
  logic   probe_active;
  logic   valid_player_position;

  modport master (
    output probe_topLeftX,
    output probe_topLeftY,
    output probe_active,
    input  valid_player_position
  );

  modport slave (
    input  probe_topLeftX,
    input  probe_topLeftY,
    input  probe_active,
    output valid_player_position
  );

endinterface

// File: rtl/player_move_ctrl.sv
// Per-frame player movement controller.
// At each start of frame the direction keys are latched and the X and Y
// moves are probed one after the other against the collision checker, so a
// diagonal move into a wall still slides along the free axis.
// Optional feature macro: PLAYER_BOUNDS_CLAMP_EN -- candidates outside the
// arena are rejected locally without occupying the checker.
module player_move_ctrl
  import bomber_pkg::*;
#(
  parameter coord_t INIT_X        = 11'd15,
  parameter coord_t INIT_Y        = 11'd48,
  parameter coord_t STEP          = 11'd1,
  parameter int     CHECK_LATENCY = 2
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               key_up,
  input  logic               key_down,
  input  logic               key_left,
  input  logic               key_right,
  player_move_ctrl_if.master chk,
  output coord_t             topLeftX,
  output coord_t             topLeftY,
  output logic               moved
);

  localparam int CNT_W = (CHECK_LATENCY > 1) ? $clog2(CHECK_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHECK_LATENCY - 1);

  move_state_t      state_q;
  coord_t           topLeftX_q;
  coord_t           topLeftY_q;
  coord_t           probe_x_q;
  coord_t           probe_y_q;
  logic             probe_active_q;
  logic             moved_q;
  logic             x_moved_q;
  logic             up_q;
  logic             down_q;
  logic [CNT_W-1:0] wait_q;

  coord_t x_cand_d;
  coord_t y_cand_d;
  logic   x_go_d;
  logic   y_go_d;
  logic   probe_done_d;
  logic   commit_d;
  coord_t x_after_d;
  coord_t y_after_d;

  // Candidate positions, per-axis go decisions and the verdict of the running probe
  always_comb begin
    // X is decided from the live keys on the start-of-frame edge itself;
    // Y is decided later from the latched keys.
    x_cand_d = step_coord(topLeftX_q, key_right, key_left, STEP);
    y_cand_d = step_coord(topLeftY_q, down_q, up_q, STEP);
    x_go_d   = axis_moves(key_right, key_left);
    y_go_d   = axis_moves(down_q, up_q);
`ifdef PLAYER_BOUNDS_CLAMP_EN
    x_go_d   = x_go_d && in_range(x_cand_d, ARENA_MIN_X, ARENA_MAX_X);
    y_go_d   = y_go_d && in_range(y_cand_d, ARENA_MIN_Y, ARENA_MAX_Y);
`endif
    // A probe phase ends either immediately (axis skipped) or on the last
    // wait cycle, which is when the checker verdict is valid.
    probe_done_d = !probe_active_q || (wait_q == CNT_LAST);
    commit_d     = probe_active_q && (wait_q == CNT_LAST) &&
                   chk.valid_player_position;
    x_after_d    = commit_d ? probe_x_q : topLeftX_q;
    y_after_d    = commit_d ? probe_y_q : topLeftY_q;
  end

  // Movement FSM with registered probe, position and moved outputs
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q        <= IDLE;
      topLeftX_q     <= INIT_X;
      topLeftY_q     <= INIT_Y;
      probe_x_q      <= INIT_X;
      probe_y_q      <= INIT_Y;
      probe_active_q <= 1'b0;
      moved_q        <= 1'b0;
      x_moved_q      <= 1'b0;
      up_q           <= 1'b0;
      down_q         <= 1'b0;
      wait_q         <= '0;
    end else begin
      moved_q <= 1'b0;
      case (state_q)
        IDLE: begin
          probe_x_q      <= topLeftX_q;
          probe_y_q      <= topLeftY_q;
          probe_active_q <= 1'b0;
          wait_q         <= '0;
          if (startOfFrame) begin
            up_q      <= key_up;
            down_q    <= key_down;
            x_moved_q <= 1'b0;
            state_q   <= PROBE_X;
            if (x_go_d) begin
              probe_x_q      <= x_cand_d;
              probe_active_q <= 1'b1;
            end
          end
        end

        PROBE_X: begin
          if (!probe_done_d) begin
            wait_q <= wait_q + 1'b1;
          end else begin
            if (commit_d) begin
              topLeftX_q <= probe_x_q;
              x_moved_q  <= 1'b1;
            end
            // Y is probed from the X position as it stands after this phase.
            wait_q         <= '0;
            probe_x_q      <= x_after_d;
            probe_y_q      <= topLeftY_q;
            probe_active_q <= 1'b0;
            state_q        <= PROBE_Y;
            if (y_go_d) begin
              probe_y_q      <= y_cand_d;
              probe_active_q <= 1'b1;
            end
          end
        end

        PROBE_Y: begin
          if (!probe_done_d) begin
            wait_q <= wait_q + 1'b1;
          end else begin
            if (commit_d) begin
              topLeftY_q <= probe_y_q;
            end
            wait_q         <= '0;
            probe_x_q      <= topLeftX_q;
            probe_y_q      <= y_after_d;
            probe_active_q <= 1'b0;
            moved_q        <= x_moved_q | commit_d;
            state_q        <= DONE;
          end
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign topLeftX           = topLeftX_q;
  assign topLeftY           = topLeftY_q;
  assign moved              = moved_q;
  assign chk.probe_topLeftX = probe_x_q;
  assign chk.probe_topLeftY = probe_y_q;
  assign chk.probe_active   = probe_active_q;

endmodule

// File: tb/tb_player_move_ctrl.sv
// Directed bench for player_move_ctrl: a table of per-frame vectors with a
// one-point wall as the collision checker, plus hand sequences for reset
// behaviour and mid-frame key/startOfFrame changes.
module tb_player_move_ctrl;
  import bomber_pkg::*;

  logic   clk;
  logic   resetN;
  logic   startOfFrame;
  logic   key_up, key_down, key_left, key_right;
  coord_t topLeftX, topLeftY;
  logic   moved;

  int checks = 0;
  int errors = 0;

  player_move_ctrl_if bus();

  player_move_ctrl dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .key_up       (key_up),
    .key_down     (key_down),
    .key_left     (key_left),
    .key_right    (key_right),
    .chk          (bus),
    .topLeftX     (topLeftX),
    .topLeftY     (topLeftY),
    .moved        (moved)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string    name;
    logic [3:0] keys;   // {up, down, left, right}
    int       rep;      // frames to run; checks apply to the last one
    bit       mid;      // change keys and re-pulse startOfFrame mid-sequence
    coord_t   bx, by;   // single blocked probe position
    coord_t   ex, ey;   // expected committed position
    int       eact;     // expected probe_active cycles in the frame
    int       emov;     // expected moved pulses in the frame
    coord_t   epx, epy; // expected last probe seen while active
  } vec_t;

  localparam coord_t NB = 11'h7FF;

  vec_t vecs[12];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One frame: pulse startOfFrame, then watch 12 cycles acting as the checker.
  task automatic run_frame(input vec_t v, output int act_n, output int mov_n,
                           output coord_t lpx, output coord_t lpy);
    act_n = 0;
    mov_n = 0;
    lpx   = '0;
    lpy   = '0;
    @(negedge clk);
    {key_up, key_down, key_left, key_right} = v.keys;
    bus.valid_player_position = 1'b1;
    startOfFrame = 1'b1;
    @(negedge clk);
    if (v.mid) begin
      {key_up, key_down, key_left, key_right} = ~v.keys;
    end else begin
      startOfFrame = 1'b0;
    end
    for (int c = 0; c < 12; c++) begin
      if (c == 1) startOfFrame = 1'b0;
      if (bus.probe_active) begin
        act_n++;
        lpx = bus.probe_topLeftX;
        lpy = bus.probe_topLeftY;
      end
      if (moved) mov_n++;
      bus.valid_player_position = !((bus.probe_topLeftX == v.bx) &&
                                    (bus.probe_topLeftY == v.by));
      @(negedge clk);
    end
    {key_up, key_down, key_left, key_right} = 4'b0000;
  endtask

  task automatic check_frame(input vec_t v, input int act_n, input int mov_n,
                             input coord_t lpx, input coord_t lpy);
    check({v.name, "_x"}, int'(topLeftX), int'(v.ex));
    check({v.name, "_y"}, int'(topLeftY), int'(v.ey));
    check({v.name, "_active_cycles"}, act_n, v.eact);
    check({v.name, "_moved_pulses"}, mov_n, v.emov);
    if (v.eact > 0) begin
      check({v.name, "_probe_x"}, int'(lpx), int'(v.epx));
      check({v.name, "_probe_y"}, int'(lpy), int'(v.epy));
    end
    $display("frame %s keys=%b pos=(%0d,%0d) active=%0d moved=%0d",
             v.name, v.keys, topLeftX, topLeftY, act_n, mov_n);
  endtask

  initial begin
    int     act_n, mov_n, found;
    coord_t lpx, lpy;
    vec_t   v;

    resetN = 1'b1;
    startOfFrame = 1'b0;
    {key_up, key_down, key_left, key_right} = 4'b0000;
    bus.valid_player_position = 1'b1;

    vecs[0]  = '{"idle0", 4'b0000, 1, 0, NB, NB, 11'd15, 11'd48, 0, 0, 11'd0, 11'd0};
    vecs[1]  = '{"idle1", 4'b0000, 1, 0, NB, NB, 11'd15, 11'd48, 0, 0, 11'd0, 11'd0};
    vecs[2]  = '{"idle2", 4'b0000, 1, 0, NB, NB, 11'd15, 11'd48, 0, 0, 11'd0, 11'd0};
`ifdef PLAYER_BOUNDS_CLAMP_EN
    vecs[3]  = '{"left_edge", 4'b0010, 1, 0, 11'd14, 11'd48, 11'd15, 11'd48, 0, 0, 11'd0, 11'd0};
`else
    vecs[3]  = '{"left_edge", 4'b0010, 1, 0, 11'd14, 11'd48, 11'd15, 11'd48, 2, 0, 11'd14, 11'd48};
`endif
    vecs[4]  = '{"right", 4'b0001, 1, 0, NB, NB, 11'd16, 11'd48, 2, 1, 11'd16, 11'd48};
    vecs[5]  = '{"down", 4'b0100, 1, 0, NB, NB, 11'd16, 11'd49, 2, 1, 11'd16, 11'd49};
    vecs[6]  = '{"lr_up", 4'b1011, 1, 0, NB, NB, 11'd16, 11'd48, 2, 1, 11'd16, 11'd48};
    vecs[7]  = '{"right_x31", 4'b0001, 31, 0, NB, NB, 11'd47, 11'd48, 2, 1, 11'd47, 11'd48};
    vecs[8]  = '{"slide", 4'b0101, 1, 0, 11'd48, 11'd48, 11'd47, 11'd49, 4, 1, 11'd47, 11'd49};
    vecs[9]  = '{"wall_x", 4'b0001, 1, 0, 11'd48, 11'd49, 11'd47, 11'd49, 2, 0, 11'd48, 11'd49};
    vecs[10] = '{"lr_only", 4'b0011, 1, 0, NB, NB, 11'd47, 11'd49, 0, 0, 11'd0, 11'd0};
    vecs[11] = '{"mid_change", 4'b0100, 1, 1, NB, NB, 11'd47, 11'd50, 2, 1, 11'd47, 11'd50};

    // Reset values
    #3 resetN = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_x", int'(topLeftX), 15);
    check("rst_y", int'(topLeftY), 48);
    check("rst_probe_x", int'(bus.probe_topLeftX), 15);
    check("rst_probe_y", int'(bus.probe_topLeftY), 48);
    check("rst_active", int'(bus.probe_active), 0);
    check("rst_moved", int'(moved), 0);
    resetN = 1'b1;
    $display("reset released pos=(%0d,%0d)", topLeftX, topLeftY);

    // Table-driven frames
    for (int i = 0; i < 12; i++) begin
      for (int r = 0; r < vecs[i].rep; r++) begin
        run_frame(vecs[i], act_n, mov_n, lpx, lpy);
      end
      check_frame(vecs[i], act_n, mov_n, lpx, lpy);
    end

    // Asynchronous reset while the Y probe is in flight
    @(negedge clk);
    {key_up, key_down, key_left, key_right} = 4'b0100;
    bus.valid_player_position = 1'b1;
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    found = 0;
    for (int c = 0; c < 8 && found == 0; c++) begin
      if (bus.probe_active) found = 1;
      else @(negedge clk);
    end
    check("rst_mid_probe_seen", found, 1);
    check("rst_mid_probe_y", int'(bus.probe_topLeftY), 51);
    #2 resetN = 1'b0;
    #1;
    check("rst_mid_x", int'(topLeftX), 15);
    check("rst_mid_y", int'(topLeftY), 48);
    check("rst_mid_probe_x", int'(bus.probe_topLeftX), 15);
    check("rst_mid_probe_yr", int'(bus.probe_topLeftY), 48);
    check("rst_mid_active", int'(bus.probe_active), 0);
    check("rst_mid_moved", int'(moved), 0);
    $display("mid-probe reset pos=(%0d,%0d) active=%0d", topLeftX, topLeftY,
             bus.probe_active);
    @(negedge clk);
    resetN = 1'b1;
    {key_up, key_down, key_left, key_right} = 4'b0000;

    v = '{"after_rst", 4'b0001, 1, 0, NB, NB, 11'd16, 11'd48, 2, 1, 11'd16, 11'd48};
    run_frame(v, act_n, mov_n, lpx, lpy);
    check_frame(v, act_n, mov_n, lpx, lpy);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
